// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the addsub issue controller
package fp_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic        mode;
    logic [31:0] op1;
    logic [31:0] op2;
  } fp_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } issue_state_t;

endpackage

// File: rtl/fp_issue_fifo.sv
// rtl/fp_issue_fifo.sv - request FIFO holding pending addsub operations
module fp_issue_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fp_op_t                   push_data,
  input  logic                     pop,
  output fp_op_t                   pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  fp_op_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_addsub_issue.sv
// rtl/fp_addsub_issue.sv - serialising issue controller for addsub; optional WAIT watchdog via FP_ISSUE_TIMEOUT_EN
module fp_addsub_issue
  import fp_pkg::*;
#(
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic        add_start,
  output logic        mode,
  output logic [31:0] op1,
  output logic [31:0] op2,
  input  logic        add_done,
  input  logic [31:0] add_result,
  input  logic        add_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  issue_state_t state;
  fp_op_t       req_op;
  fp_op_t       head_op;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [AW:0]  fifo_count;

  assign req_op.mode = req_mode;
  assign req_op.op1  = req_op1;
  assign req_op.op2  = req_op2;

  // Ready comes from the registered count only, never from a same-cycle pop.
  assign req_ready = (fifo_count != DEPTH_CNT);
  assign fifo_push = req_valid & ~fifo_full;
  assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty;
  assign busy      = (state != ST_IDLE) | ~fifo_empty;

  fp_issue_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(req_op),
    .pop      (fifo_pop),
    .pop_data (head_op),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

`ifdef FP_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
  assign rsp_timeout        = 1'b0;
`endif

  // Issue FSM: pop -> launch pulse -> wait for completion -> hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      add_start    <= 1'b0;
      mode         <= MODE_ADD;
      op1          <= '0;
      op2          <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
`ifdef FP_ISSUE_TIMEOUT_EN
      rsp_timeout  <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      add_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mode      <= head_op.mode;
            op1       <= head_op.op1;
            op2       <= head_op.op2;
            add_start <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // add_done seen here belongs to nothing we launched; ignore it.
          state <= ST_WAIT;
`ifdef FP_ISSUE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (add_done) begin
            rsp_result   <= add_result;
            rsp_overflow <= add_overflow;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
`ifdef FP_ISSUE_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_issue.sv
// tb/tb_fp_addsub_issue.sv - directed bench for fp_addsub_issue with behavioural addsub model
module tb_fp_addsub_issue;
  import fp_pkg::*;

  localparam int DEPTH = 2;
  localparam int TO    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mode = 1'b0;
  logic [31:0] req_op1 = '0;
  logic [31:0] req_op2 = '0;
  logic        add_start;
  logic        mode;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        add_done = 1'b0;
  logic [31:0] add_result = '0;
  logic        add_overflow = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_timeout;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int model_lat = 1;
  int model_cnt = 0;
  logic stray_req = 1'b0;
  logic m_mode = 1'b0;
  logic [31:0] m_op1 = '0;
  logic [31:0] m_op2 = '0;
  logic inflight = 1'b0;
  int start_viol = 0;

  fp_addsub_issue #(
    .DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_op1(req_op1), .req_op2(req_op2),
    .add_start(add_start), .mode(mode), .op1(op1), .op2(op2),
    .add_done(add_done), .add_result(add_result), .add_overflow(add_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Hand-computed IEEE-754 answers for the operand pairs this bench uses.
  function automatic logic [32:0] fmodel(input logic m, input logic [31:0] a, input logic [31:0] b);
    case ({m, a, b})
      {MODE_ADD, 32'h40200000, 32'h40600000}: return {1'b0, 32'h40C00000};
      {MODE_ADD, 32'h41200000, 32'hC0A00000}: return {1'b0, 32'h40A00000};
      {MODE_SUB, 32'h40000000, 32'h40400000}: return {1'b0, 32'hBF800000};
      {MODE_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF}: return {1'b1, 32'h7F800000};
      {MODE_SUB, 32'h3F800000, 32'h3F800000}: return {1'b0, 32'h00000000};
      {MODE_ADD, 32'h3FC00000, 32'h3E800000}: return {1'b0, 32'h3FE00000};
      default:                                return {1'b0, 32'hFFFFFFFF};
    endcase
  endfunction

  // addsub stand-in: done asserted model_lat cycles after the start cycle; 0 means never.
  always @(negedge clk) begin
    add_done     = 1'b0;
    add_result   = '0;
    add_overflow = 1'b0;
    if (rst) begin
      model_cnt = 0;
    end else if (stray_req) begin
      add_done     = 1'b1;
      add_result   = 32'h12345678;
      add_overflow = 1'b1;
      stray_req    = 1'b0;
    end else if (add_start) begin
      model_cnt = model_lat;
      m_mode = mode;
      m_op1  = op1;
      m_op2  = op2;
    end else if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) begin
        {add_overflow, add_result} = fmodel(m_mode, m_op1, m_op2);
        add_done = 1'b1;
      end
    end
  end

  // Launch must never overlap an in-flight operation or a pending response.
  always @(posedge clk) begin
    if (rst) begin
      inflight = 1'b0;
    end else begin
      if (add_start && (inflight || rsp_valid)) start_viol = start_viol + 1;
      if (add_start) inflight = 1'b1;
      if (rsp_valid && rsp_ready) inflight = 1'b0;
    end
  end

  logic        tv_m   [5] = '{MODE_ADD, MODE_ADD, MODE_SUB, MODE_ADD, MODE_SUB};
  logic [31:0] tv_a   [5] = '{32'h40200000, 32'h41200000, 32'h40000000, 32'h7F7FFFFF, 32'h3F800000};
  logic [31:0] tv_b   [5] = '{32'h40600000, 32'hC0A00000, 32'h40400000, 32'h7F7FFFFF, 32'h3F800000};
  logic [31:0] tv_res [5] = '{32'h40C00000, 32'h40A00000, 32'hBF800000, 32'h7F800000, 32'h00000000};
  logic        tv_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int          tv_lat [5] = '{3, 1, 2, 1, 4};

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++; if (add_start !== 1'b0) begin miscompares++; $display("FAIL reset_add_start: got %b want 0", add_start); end
    vectors++; if (mode !== 1'b0) begin miscompares++; $display("FAIL reset_mode: got %b want 0", mode); end
    vectors++; if (op1 !== 32'h0 || op2 !== 32'h0) begin miscompares++; $display("FAIL reset_ops: got %h/%h want 0/0", op1, op2); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_result !== 32'h0 || rsp_overflow !== 1'b0 || rsp_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_regs: got %h/%b/%b want 0/0/0", rsp_result, rsp_overflow, rsp_timeout); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    stray_req = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || add_start) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL reset_stray_done: got %0d active cycles want 0", seen); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_stray_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    int c0;
    rsp_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      model_lat = tv_lat[v];
      c0 = cyc;
      req_valid = 1'b1; req_mode = tv_m[v]; req_op1 = tv_a[v]; req_op2 = tv_b[v];
      @(negedge clk);
      req_valid = 1'b0;
      vectors++; if (add_start !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL dir%0d_cycle1: got start=%b busy=%b want 0/1", v, add_start, busy); end
      @(negedge clk);
      vectors++; if (add_start !== 1'b1) begin miscompares++; $display("FAIL dir%0d_launch: got start=%b want 1 at cycle 2", v, add_start); end
      vectors++; if (mode !== tv_m[v] || op1 !== tv_a[v] || op2 !== tv_b[v]) begin miscompares++; $display("FAIL dir%0d_operands: got %b %h %h want %b %h %h", v, mode, op1, op2, tv_m[v], tv_a[v], tv_b[v]); end
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (rsp_valid) break;
      end
      vectors++; if (cyc - c0 != 3 + tv_lat[v] || rsp_valid !== 1'b1) begin miscompares++; $display("FAIL dir%0d_rsp_cycle: got cycle %0d valid=%b want cycle %0d", v, cyc - c0, rsp_valid, 3 + tv_lat[v]); end
      vectors++; if (rsp_result !== tv_res[v]) begin miscompares++; $display("FAIL dir%0d_result: got %h want %h", v, rsp_result, tv_res[v]); end
      vectors++; if (rsp_overflow !== tv_ovf[v] || rsp_timeout !== 1'b0) begin miscompares++; $display("FAIL dir%0d_flags: got ovf=%b to=%b want %b/0", v, rsp_overflow, rsp_timeout, tv_ovf[v]); end
      vectors++; if (op1 !== tv_a[v]) begin miscompares++; $display("FAIL dir%0d_op_hold: got %h want %h", v, op1, tv_a[v]); end
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL dir%0d_handshake: got rsp_valid=%b want 0", v, rsp_valid); end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c0;
    int ls [2];
    int rc [2];
    logic [31:0] rr [2];
    int nl, nr;
    nl = 0; nr = 0;
    ls[0] = -1; ls[1] = -1; rc[0] = -1; rc[1] = -1; rr[0] = '0; rr[1] = '0;
    rsp_ready = 1'b1;
    model_lat = 1;
    c0 = cyc;
    req_valid = 1'b1; req_mode = MODE_ADD; req_op1 = 32'h3FC00000; req_op2 = 32'h3E800000;
    @(negedge clk);
    req_op1 = 32'h40200000; req_op2 = 32'h40600000;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (add_start && nl < 2) begin ls[nl] = cyc - c0; nl++; end
      if (rsp_valid && nr < 2) begin rc[nr] = cyc - c0; rr[nr] = rsp_result; nr++; end
      @(negedge clk);
    end
    vectors++; if (ls[0] != 2 || ls[1] != 6) begin miscompares++; $display("FAIL b2b_launch: got %0d,%0d want 2,6", ls[0], ls[1]); end
    vectors++; if (rc[0] != 4 || rc[1] != 8) begin miscompares++; $display("FAIL b2b_rsp_cycle: got %0d,%0d want 4,8", rc[0], rc[1]); end
    vectors++; if (rr[0] !== 32'h3FE00000 || rr[1] !== 32'h40C00000) begin miscompares++; $display("FAIL b2b_results: got %h,%h want 3fe00000,40c00000", rr[0], rr[1]); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_r [3] = '{32'hBF800000, 32'h40A00000, 32'h7F800000};
    logic        exp_o [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] held;
    rsp_ready = 1'b0;
    model_lat = 2;
    req_valid = 1'b1; req_mode = MODE_SUB; req_op1 = 32'h40000000; req_op2 = 32'h40400000;
    @(negedge clk);
    req_mode = MODE_ADD; req_op1 = 32'h41200000; req_op2 = 32'hC0A00000;
    @(negedge clk);
    req_mode = MODE_ADD; req_op1 = 32'h7F7FFFFF; req_op2 = 32'h7F7FFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full: got req_ready=%b want 0", req_ready); end
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    held = rsp_result;
    repeat (3) begin
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1 || rsp_result !== held || req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold: got valid=%b result=%h ready=%b want 1/%h/0", rsp_valid, rsp_result, req_ready, held); end
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        if (rsp_valid) break;
        @(negedge clk);
      end
      vectors++; if (rsp_valid !== 1'b1 || rsp_result !== exp_r[k] || rsp_overflow !== exp_o[k]) begin miscompares++; $display("FAIL bp_order%0d: got valid=%b %h ovf=%b want 1 %h ovf=%b", k, rsp_valid, rsp_result, rsp_overflow, exp_r[k], exp_o[k]); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_drained: got busy=%b ready=%b want 0/1", busy, req_ready); end
    vectors++; if (start_viol != 0) begin miscompares++; $display("FAIL bp_no_overlap: got %0d overlapping launches want 0", start_viol); end
  endtask

  task automatic test_reset_wait();
    int seen;
    rsp_ready = 1'b1;
    model_lat = 0;
    req_valid = 1'b1; req_mode = MODE_ADD; req_op1 = 32'h40200000; req_op2 = 32'h40600000;
    @(negedge clk);
    req_op1 = 32'h41200000; req_op2 = 32'hC0A00000;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstw_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL rstw_cleared: got busy=%b ready=%b want 0/1", busy, req_ready); end
    vectors++; if (rsp_valid !== 1'b0 || add_start !== 1'b0 || op1 !== 32'h0) begin miscompares++; $display("FAIL rstw_outputs: got valid=%b start=%b op1=%h want 0/0/0", rsp_valid, add_start, op1); end
    stray_req = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || add_start || busy) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rstw_no_response: got %0d active cycles want 0", seen); end
    rsp_ready = 1'b0;
  endtask

`ifdef FP_ISSUE_TIMEOUT_EN
  task automatic test_timeout();
    int c0;
    rsp_ready = 1'b0;
    model_lat = 0;
    c0 = cyc;
    req_valid = 1'b1; req_mode = MODE_ADD; req_op1 = 32'h40200000; req_op2 = 32'h40600000;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    vectors++; if (cyc - c0 != 11 || rsp_valid !== 1'b1) begin miscompares++; $display("FAIL to_cycle: got cycle %0d valid=%b want 11", cyc - c0, rsp_valid); end
    vectors++; if (rsp_timeout !== 1'b1 || rsp_result !== 32'h0 || rsp_overflow !== 1'b0) begin miscompares++; $display("FAIL to_flags: got to=%b %h ovf=%b want 1 0 0", rsp_timeout, rsp_result, rsp_overflow); end
    rsp_ready = 1'b1;
    @(negedge clk);
    model_lat = 8;
    c0 = cyc;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    vectors++; if (cyc - c0 != 11 || rsp_timeout !== 1'b0 || rsp_result !== 32'h40C00000) begin miscompares++; $display("FAIL to_done_priority: got cycle %0d to=%b %h want 11 0 40c00000", cyc - c0, rsp_timeout, rsp_result); end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_wait();
`ifdef FP_ISSUE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
